param_sequencer: RTL and testbench
==================================

Name: param_sequencer

Overview:
- Controller that fetches quantized CNN parameters from a synchronous parameter ROM and streams them to the conv/FC datapath over a valid/ready handshake.
- Conv mode: streams one 3x3 filter (9 weights, row-major) followed by its bias, 10 words per filter.
- FC mode: streams the FC bias vector.
- Sits between the parameter ROM and the conv2d / fully-connected engines; the top-level FSM issues one `start` per parameter set.

Parameters:
- DATA_W, 16, width of each signed parameter word.
- ROM_AW, 9, ROM address width.
- NUM_FILTERS, 3, number of conv filters stored.
- CONV_WORDS, 10, words per conv filter (9 taps + 1 bias).
- CONV_BASE, 0, ROM address of filter 0, tap 0.
- FC_BASE, 30, ROM address of FC bias 0.
- FC_WORDS, 10, number of FC bias words.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- mode  in  1  0 = conv filter, 1 = FC bias; sampled with start.
- filt_sel  in  2  filter index; sampled with start; ignored when mode=1.
- busy  out  1  high from the cycle after an accepted start until DONE exits.
- done  out  1  one-cycle pulse after the last word is accepted.
- err  out  1  one-cycle pulse when start has mode=0 and filt_sel>=NUM_FILTERS.
- rom_en  out  1  ROM read enable.
- rom_addr  out  ROM_AW  ROM read address.
- rom_data  in  DATA_W  ROM read data, valid exactly 1 cycle after rom_en.
- out_data  out  DATA_W  parameter word (two's complement).
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts when out_valid && out_ready.
- out_is_bias  out  1  high on bias words: conv word index 9, or any word in FC mode.
- out_last  out  1  high on the final word of the set.

Behaviour:

Reset:
- All outputs are 0; FSM goes to IDLE; word counter is 0.
- Reset mid-transfer aborts immediately: no done pulse, and out_valid drops the next cycle.

States:
- IDLE
  - start && valid selection -> latch base address and word count (CONV_BASE + filt_sel*CONV_WORDS with count CONV_WORDS, or FC_BASE with count FC_WORDS); go to FETCH.
  - start && invalid selection -> pulse err next cycle; stay in IDLE.
  - start while not in IDLE is ignored (no err, no restart).
- FETCH
  - rom_en=1 for one cycle, rom_addr = base + idx; go to WAIT.
- WAIT
  - Capture rom_data into out_data; set out_valid=1.
  - Set out_last (idx == count-1) and out_is_bias; go to HOLD.
- HOLD
  - out_valid and out_data are held stable while out_ready=0.
  - On handshake: out_valid=0 next cycle.
  - If last word -> DONE; otherwise idx+1 -> FETCH.
- DONE
  - done=1 for one cycle; busy=0 next; go to IDLE.

Timing:
- First out_valid is 3 cycles after start is sampled (start edge -> FETCH -> WAIT -> valid).
- Peak throughput is one word per 3 cycles with out_ready held high.
- Full set with out_ready=1 takes 3*count cycles, then the done pulse.

Handshake and width rules:
- No word is ever dropped or duplicated under back-pressure.
- Data is passed bit-exact; no sign extension or arithmetic is applied.
- rom_addr is computed modulo 2^ROM_AW; no wrap is needed for the defaults (maximum address 39).
- out_ready high while out_valid=0 has no effect.
- rom_en is never asserted outside FETCH.

Test Plan:
- Directed 1, conv filter 0, no back-pressure:
  - Stimulus: ROM[0..9] = 46,-9,-127,70,-23,-93,-20,-88,-86,-843; start, mode=0, filt_sel=0; out_ready=1.
  - Response: 10 words in order (0x002E, 0xFFF7, ..., 0xFCB5); rom_addr 0..9.
  - Response: out_is_bias and out_last only on 0xFCB5; done exactly 1 cycle after its handshake.
- Directed 2, conv filter 2:
  - Stimulus: start, mode=0, filt_sel=2.
  - Response: rom_addr sequence 20..29.
- Directed 3, FC bias:
  - Stimulus: ROM[30..39] = -48,1081,-146,-256,-109,976,31,466,-905,33; start, mode=1.
  - Response: all 10 words have out_is_bias=1; word 1 = 0x0439, word 8 = 0xFC77; out_last on 0x0021.
- Directed 4, back-pressure:
  - Stimulus: out_ready=0 for 5 cycles on word 3.
  - Response: out_data holds 0x0046 with out_valid=1 throughout; no rom_en during the stall; the sequence completes unchanged.
- Directed 5, invalid selection:
  - Stimulus: start, mode=0, filt_sel=3.
  - Response: err pulses one cycle; busy stays 0; no rom_en.
  - Stimulus: start asserted during an active transfer.
  - Response: ignored; transfer unaffected.
- Directed 6, reset mid-transfer:
  - Stimulus: rst asserted during word 5.
  - Response: all outputs 0 the next cycle; no done pulse.
  - Stimulus: new start after reset.
  - Response: the set restarts from word 0.

Source files
------------

// File: rtl/param_sequencer.sv
// Parameter ROM sequencer: fetches one conv filter (9 taps + bias) or the FC bias
// vector from a synchronous ROM and streams it out over a valid/ready handshake.
module param_sequencer #(
    parameter int DATA_W      = 16,
    parameter int ROM_AW      = 9,
    parameter int NUM_FILTERS = 3,
    parameter int CONV_WORDS  = 10,
    parameter int CONV_BASE   = 0,
    parameter int FC_BASE     = 30,
    parameter int FC_WORDS    = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     mode,
    input  logic [1:0]               filt_sel,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic                     rom_en,
    output logic [ROM_AW-1:0]        rom_addr,
    input  logic signed [DATA_W-1:0] rom_data,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_is_bias,
    output logic                     out_last
);

    localparam int MAX_WORDS = (CONV_WORDS > FC_WORDS) ? CONV_WORDS : FC_WORDS;
    localparam int CNT_W     = $clog2(MAX_WORDS + 1);

    typedef enum logic [2:0] {IDLE, FETCH, WAIT_RD, HOLD, DONE} state_t;

    state_t             state;
    logic [ROM_AW-1:0]  base;
    logic [CNT_W-1:0]   idx;
    logic [CNT_W-1:0]   count;
    logic               mode_q;
    logic [CNT_W-1:0]   nxt_idx;

    assign nxt_idx = idx + 1'b1;

    function automatic logic [ROM_AW-1:0] conv_base(input logic [1:0] sel);
        return ROM_AW'(CONV_BASE) + ROM_AW'(sel) * ROM_AW'(CONV_WORDS);
    endfunction

    function automatic logic sel_ok(input logic m, input logic [1:0] sel);
        return m || (32'(sel) < 32'(NUM_FILTERS));
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            rom_en      <= 1'b0;
            rom_addr    <= '0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            out_is_bias <= 1'b0;
            out_last    <= 1'b0;
            base        <= '0;
            idx         <= '0;
            count       <= '0;
            mode_q      <= 1'b0;
        end else begin
            done   <= 1'b0;
            err    <= 1'b0;
            rom_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (sel_ok(mode, filt_sel)) begin
                            state  <= FETCH;
                            busy   <= 1'b1;
                            idx    <= '0;
                            mode_q <= mode;
                            rom_en <= 1'b1;
                            if (mode) begin
                                base     <= ROM_AW'(FC_BASE);
                                rom_addr <= ROM_AW'(FC_BASE);
                                count    <= CNT_W'(FC_WORDS);
                            end else begin
                                base     <= conv_base(filt_sel);
                                rom_addr <= conv_base(filt_sel);
                                count    <= CNT_W'(CONV_WORDS);
                            end
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                FETCH: state <= WAIT_RD;
                WAIT_RD: begin
                    // ROM word is valid now, one cycle after rom_en
                    out_data    <= rom_data;
                    out_valid   <= 1'b1;
                    out_last    <= (idx == count - 1'b1);
                    out_is_bias <= mode_q || (idx == CNT_W'(CONV_WORDS - 1));
                    state       <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid   <= 1'b0;
                        out_last    <= 1'b0;
                        out_is_bias <= 1'b0;
                        if (out_last) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            idx      <= nxt_idx;
                            rom_en   <= 1'b1;
                            rom_addr <= base + ROM_AW'(nxt_idx);
                            state    <= FETCH;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_param_sequencer.sv
// Bench for param_sequencer: ROM model, word-queue reference model checked every
// cycle, directed scenarios with literal expectations, then randomized sets.
module tb_param_sequencer;

    localparam int DATA_W = 16;
    localparam int ROM_AW = 9;
    localparam int NF     = 3;
    localparam int CW     = 10;
    localparam int FCB    = 30;
    localparam int FCW    = 10;

    logic clk, rst, start, mode, busy, done, err, rom_en, out_valid, out_ready;
    logic out_is_bias, out_last;
    logic [1:0] filt_sel;
    logic [ROM_AW-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data, out_data;

    logic [DATA_W-1:0] mem [0:511];

    param_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .filt_sel(filt_sel),
        .busy(busy), .done(done), .err(err), .rom_en(rom_en), .rom_addr(rom_addr),
        .rom_data(rom_data), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_is_bias(out_is_bias), .out_last(out_last)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) if (rom_en) rom_data <= mem[rom_addr];

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [ROM_AW-1:0] addr;
        logic [DATA_W-1:0] data;
        bit                bias;
        bit                last;
    } word_t;

    word_t q[$];
    bit in_set = 0, exp_valid = 0, exp_done = 0, exp_err = 0, rst_chk = 1;
    int wait_c = 0;
    int cyc = 0;

    // per-set logs for the directed literal checks
    logic [DATA_W-1:0] lw_data [0:15];
    bit lw_bias [0:15];
    bit lw_last [0:15];
    int la [0:15];
    int log_n, addr_n, done_seen, bias_n;
    int start_cyc, done_cyc, first_valid;

    always @(negedge clk) begin
        bit exp_fetch, hs, accept, nd, ne;
        word_t w;
        int b;
        cyc++;
        if (wait_c > 0) begin
            wait_c--;
            if (wait_c == 0) exp_valid = 1;
        end
        exp_fetch = (wait_c == 2);
        if (rst_chk) begin
            check("reset_outputs",
                  {busy, done, err, rom_en, out_valid, out_is_bias, out_last, 16'(rom_addr)}, 0);
            check("reset_out_data", out_data, 0);
            rst_chk = 0;
        end
        check("busy", busy, in_set);
        check("done", done, exp_done);
        check("err", err, exp_err);
        check("rom_en", rom_en, exp_fetch);
        check("out_valid", out_valid, exp_valid);
        if (exp_fetch && q.size() > 0) begin
            check("rom_addr", rom_addr, q[0].addr);
            if (addr_n < 16) la[addr_n] = int'(rom_addr);
            addr_n++;
        end
        if (exp_valid && q.size() > 0) begin
            check("out_data", out_data, q[0].data);
            check("out_is_bias", out_is_bias, q[0].bias);
            check("out_last", out_last, q[0].last);
            if (first_valid < 0) first_valid = cyc;
        end
        if (done) begin
            done_seen++;
            done_cyc = cyc;
        end

        hs = exp_valid && out_ready && (q.size() > 0);
        accept = start && !in_set;
        nd = 0;
        ne = 0;
        if (rst) begin
            q.delete();
            in_set = 0; wait_c = 0; exp_valid = 0; exp_done = 0; exp_err = 0;
            rst_chk = 1;
        end else begin
            ne = accept && !mode && (int'(filt_sel) >= NF);
            if (hs) begin
                w = q.pop_front();
                if (log_n < 16) begin
                    lw_data[log_n] = out_data;
                    lw_bias[log_n] = out_is_bias;
                    lw_last[log_n] = out_last;
                end
                if (out_is_bias) bias_n++;
                log_n++;
                exp_valid = 0;
                if (w.last) nd = 1;
                else wait_c = 3;
            end
            if (accept && !ne) begin
                b = mode ? FCB : int'(filt_sel) * CW;
                for (int k = 0; k < (mode ? FCW : CW); k++) begin
                    w.addr = ROM_AW'(b + k);
                    w.data = mem[b + k];
                    w.bias = mode || (k == CW - 1);
                    w.last = (k == (mode ? FCW : CW) - 1);
                    q.push_back(w);
                end
                wait_c = 3;
                start_cyc = cyc;
            end
            if (exp_done) in_set = 0;
            if (accept && !ne) in_set = 1;
            exp_done = nd;
            exp_err = ne;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_set(input bit m, input logic [1:0] s, input bit rnd,
                           input int stall_word, input logic [15:0] stall_val,
                           input int rst_word, input int intrude);
        int stalls = 0;
        bit aborted = 0;
        log_n = 0; addr_n = 0; done_seen = 0; bias_n = 0; first_valid = -1;
        start = 1; mode = m; filt_sel = s; out_ready = 1;
        tick();
        start = 0;
        for (int c = 0; c < 600 && done_seen == 0 && !aborted; c++) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (stall_word >= 0 && log_n == stall_word && out_valid && stalls < 5) begin
                out_ready = 0;
                stalls++;
                check("stall_valid", out_valid, 1);
                check("stall_data", out_data, stall_val);
            end
            if (c == intrude) begin
                start = 1;
                mode = 1'($urandom_range(0, 1));
                filt_sel = 2'($urandom_range(0, 3));
            end
            if (rst_word >= 0 && log_n == rst_word && out_valid) begin
                rst = 1;
                aborted = 1;
            end
            tick();
            rst = 0;
            start = 0;
        end
        if (!aborted) check("set_complete", done_seen, 1);
    endtask

    task automatic bad_start();
        start = 1; mode = 0; filt_sel = 2'd3;
        tick();
        start = 0;
        check("err_pulse", err, 1);
        check("err_busy", busy, 0);
        check("err_rom_en", rom_en, 0);
        tick();
        check("err_clear", err, 0);
        tick();
    endtask

    initial begin
        int v1[10] = '{46, -9, -127, 70, -23, -93, -20, -88, -86, -843};
        int v3[10] = '{-48, 1081, -146, -256, -109, 976, 31, 466, -905, 33};
        rst = 1; start = 0; mode = 0; filt_sel = 0; out_ready = 0;
        log_n = 0; addr_n = 0; done_seen = 0; bias_n = 0; first_valid = -1;
        start_cyc = 0; done_cyc = 0;
        for (int i = 0; i < 512; i++) mem[i] = 16'($urandom);
        for (int i = 0; i < 10; i++) begin
            mem[i] = 16'(v1[i]);
            mem[FCB + i] = 16'(v3[i]);
        end
        repeat (3) tick();
        rst = 0;
        tick();

        // conv filter 0, no back-pressure
        run_set(0, 2'd0, 0, -1, 16'h0, -1, -1);
        check("d1_w0", lw_data[0], 16'h002E);
        check("d1_w1", lw_data[1], 16'hFFF7);
        check("d1_w9", lw_data[9], 16'hFCB5);
        check("d1_last9", lw_last[9], 1);
        check("d1_bias9", lw_bias[9], 1);
        check("d1_last8", lw_last[8], 0);
        check("d1_bias_cnt", bias_n, 1);
        check("d1_addr0", la[0], 0);
        check("d1_addr9", la[9], 9);
        check("d1_words", log_n, 10);
        check("d1_first_valid_lat", first_valid - start_cyc, 3);
        check("d1_done_lat", done_cyc - start_cyc, 31);
        tick();

        // conv filter 2 with a start injected mid-transfer
        run_set(0, 2'd2, 0, -1, 16'h0, -1, 7);
        check("d2_addr0", la[0], 20);
        check("d2_addr9", la[9], 29);
        check("d2_words", log_n, 10);
        tick();

        // FC bias vector
        run_set(1, 2'd0, 0, -1, 16'h0, -1, -1);
        check("d3_w1", lw_data[1], 16'h0439);
        check("d3_w8", lw_data[8], 16'hFC77);
        check("d3_w9", lw_data[9], 16'h0021);
        check("d3_last9", lw_last[9], 1);
        check("d3_bias_cnt", bias_n, 10);
        check("d3_addr0", la[0], 30);
        tick();

        // back-pressure on word 3
        run_set(0, 2'd0, 0, 3, 16'h0046, -1, -1);
        check("d4_w3", lw_data[3], 16'h0046);
        check("d4_w9", lw_data[9], 16'hFCB5);
        check("d4_words", log_n, 10);
        check("d4_done_lat", done_cyc - start_cyc, 36);
        tick();

        // invalid selection
        bad_start();

        // reset during word 5, then restart
        run_set(0, 2'd1, 0, -1, 16'h0, 5, -1);
        repeat (3) tick();
        check("d6_no_done", done_seen, 0);
        check("d6_words", log_n, 5);
        run_set(0, 2'd1, 0, -1, 16'h0, -1, -1);
        check("d6_restart_addr0", la[0], 10);
        check("d6_restart_w0", lw_data[0], mem[10]);
        check("d6_restart_words", log_n, 10);
        tick();

        // randomized sets
        for (int it = 0; it < 30; it++) begin
            bit m;
            logic [1:0] s;
            if (it % 8 == 7)
                for (int i = 0; i < 40; i++) mem[i] = 16'($urandom);
            m = 1'($urandom_range(0, 1));
            s = 2'($urandom_range(0, 3));
            if (!m && int'(s) >= NF) bad_start();
            else begin
                run_set(m, s, 1, -1, 16'h0, ($urandom_range(0, 9) == 0) ? 4 : -1,
                        int'($urandom_range(0, 40)));
                check("rnd_words_nonzero", 32'(log_n > 0), 1);
                tick();
            end
        end

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_err);
        $fatal(1);
    end

endmodule
